// File: rtl/gpu_cache_pkg.sv
// Shared definitions for the texture cache and its refill path.
package gpu_cache_pkg;

  localparam int VRAM_WORD_AW = 17;
  localparam int LOOK_AW      = 19;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DATA   = 2'd2,
    SETTLE = 2'd3
  } fillState_t;

  // Lookup addresses count halfwords; four halfwords make one 64-bit VRAM word.
  function automatic logic [VRAM_WORD_AW-1:0] wordOf(input logic [LOOK_AW-1:0] lookAdr);
    return VRAM_WORD_AW'(lookAdr >> 2);
  endfunction

endpackage

// File: rtl/cache_write_port_mux.sv
// Arbitrates the single cache write port between snooped bus writes and
// refill data. Snoops always win; a colliding fill waits in a one-entry
// buffer and is thrown away if a newer snoop lands on the same word.
module cache_write_port_mux
  import gpu_cache_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    clearCache,
  input  logic                    spyWrite,
  input  logic [VRAM_WORD_AW-1:0] spyAdr,
  input  logic [63:0]             spyData,
  input  logic                    fillWrite,
  input  logic [VRAM_WORD_AW-1:0] fillAdr,
  input  logic [63:0]             fillData,
  output logic                    write,
  output logic [VRAM_WORD_AW-1:0] adressIn,
  output logic [63:0]             dataIn,
  output logic                    holdPending
);

  logic                    holdValid;
  logic [VRAM_WORD_AW-1:0] holdAdr;
  logic [63:0]             holdData;

  logic                    pendValid;
  logic [VRAM_WORD_AW-1:0] pendAdr;
  logic [63:0]             pendData;

  logic                    writeNext;
  logic [VRAM_WORD_AW-1:0] adressNext;
  logic [63:0]             dataNext;
  logic                    holdValidNext;
  logic [VRAM_WORD_AW-1:0] holdAdrNext;
  logic [63:0]             holdDataNext;

  // Choose the next cache write; a displaced fill (new or already held) goes to the buffer unless the snoop overwrote its word.
  always_comb begin
    pendValid     = fillWrite || (holdValid && !clearCache);
    pendAdr       = fillWrite ? fillAdr  : holdAdr;
    pendData      = fillWrite ? fillData : holdData;
    writeNext     = 1'b0;
    adressNext    = adressIn;
    dataNext      = dataIn;
    holdValidNext = 1'b0;
    holdAdrNext   = holdAdr;
    holdDataNext  = holdData;
    if (spyWrite) begin
      writeNext  = 1'b1;
      adressNext = spyAdr;
      dataNext   = spyData;
      if (pendValid && (pendAdr != spyAdr)) begin
        holdValidNext = 1'b1;
        holdAdrNext   = pendAdr;
        holdDataNext  = pendData;
      end
    end else if (pendValid) begin
      writeNext  = 1'b1;
      adressNext = pendAdr;
      dataNext   = pendData;
    end
  end

  // Register the write port and the hold buffer.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      write     <= 1'b0;
      adressIn  <= '0;
      dataIn    <= '0;
      holdValid <= 1'b0;
      holdAdr   <= '0;
      holdData  <= '0;
    end else begin
      write     <= writeNext;
      adressIn  <= adressNext;
      dataIn    <= dataNext;
      holdValid <= holdValidNext;
      holdAdr   <= holdAdrNext;
      holdData  <= holdDataNext;
    end
  end

  assign holdPending = holdValid;

endmodule

// File: rtl/texture_cache_filler.sv
// Refill controller for the dual-port texture cache: fetches one missing
// VRAM word at a time and writes it back, sharing the cache write port
// with forwarded bus snoops.
module texture_cache_filler
  import gpu_cache_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_clearCache,
  input  logic                    i_isMissA,
  input  logic                    i_isMissB,
  input  logic [LOOK_AW-1:0]      i_adressLookA,
  input  logic [LOOK_AW-1:0]      i_adressLookB,
  input  logic                    i_spyWrite,
  input  logic [VRAM_WORD_AW-1:0] i_spyAdr,
  input  logic [63:0]             i_spyData,
  output logic                    o_memReq,
  output logic [VRAM_WORD_AW-1:0] o_memAdr,
  input  logic                    i_memAck,
  input  logic                    i_memDataValid,
  input  logic [63:0]             i_memData,
  output logic                    o_write,
  output logic [VRAM_WORD_AW-1:0] o_adressIn,
  output logic [63:0]             o_dataIn,
  output logic                    o_busy
);

  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  fillState_t              state;
  fillState_t              stateNext;
  logic [VRAM_WORD_AW-1:0] fillAdr;
  logic [VRAM_WORD_AW-1:0] fillAdrNext;
  logic                    stale;
  logic                    staleNext;
  logic [1:0]              settleCnt;
  logic [1:0]              settleCntNext;
  logic                    spyHitsFill;
  logic                    fillWrite;
  logic                    holdPending;

  assign spyHitsFill = i_spyWrite && (i_spyAdr == fillAdr);

  // State register plus the fetch address, stale flag and settle counter.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= IDLE;
      fillAdr   <= '0;
      stale     <= 1'b0;
      settleCnt <= '0;
    end else begin
      state     <= stateNext;
      fillAdr   <= fillAdrNext;
      stale     <= staleNext;
      settleCnt <= settleCntNext;
    end
  end

  // Fetch sequencing; a new fetch waits while a displaced fill is still queued so the buffer never overflows.
  always_comb begin
    stateNext     = state;
    fillAdrNext   = fillAdr;
    staleNext     = stale;
    settleCntNext = settleCnt;
    fillWrite     = 1'b0;
    case (state)
      IDLE: begin
        if (!holdPending && (i_isMissA || i_isMissB)) begin
          fillAdrNext = i_isMissA ? wordOf(i_adressLookA) : wordOf(i_adressLookB);
          staleNext   = 1'b0;
          stateNext   = REQ;
        end
      end
      REQ: begin
        if (i_clearCache || spyHitsFill) staleNext = 1'b1;
        if (i_memAck) stateNext = DATA;
      end
      DATA: begin
        if (i_clearCache || spyHitsFill) staleNext = 1'b1;
        if (i_memDataValid) begin
          fillWrite     = !(stale || i_clearCache || spyHitsFill);
          settleCntNext = '0;
          stateNext     = SETTLE;
        end
      end
      SETTLE: begin
        if (settleCnt == SETTLE_LAST) stateNext = IDLE;
        else settleCntNext = settleCnt + 2'd1;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign o_memReq = (state == REQ);
  assign o_memAdr = fillAdr;
  assign o_busy   = (state != IDLE);

  cache_write_port_mux writePort (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .clearCache  (i_clearCache),
    .spyWrite    (i_spyWrite),
    .spyAdr      (i_spyAdr),
    .spyData     (i_spyData),
    .fillWrite   (fillWrite),
    .fillAdr     (fillAdr),
    .fillData    (i_memData),
    .write       (o_write),
    .adressIn    (o_adressIn),
    .dataIn      (o_dataIn),
    .holdPending (holdPending)
  );

endmodule
